seg_counter_mux: RTL and testbench

SEG_COUNTER_MUX -- requirements
Module: seg_counter_mux

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_counter_mux_if.sv | 31 +++
 rtl/seg_decoder.sv | 27 ++
 rtl/seg_counter_mux.sv | 148 ++++++++++++++
 tb/tb_seg_counter_mux.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared BCD digit type and 7-segment codes (gfedcba, active-high)
// for the seg_counter_mux slice.
package seg_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  // Active-low blank pattern, also used for invalid digits
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg_counter_mux_if.sv
// Signal bundle for the seg_counter_mux control inputs and
// count/display outputs.
interface seg_counter_mux_if #(
  parameter int DIGITS = 4
) (
  input logic clk
);

  logic                  en;
  logic                  up;
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   value;
  logic                  carry;
  logic [6:0]            seg;
  logic [7:0]            an;

  modport master (
    input  clk,
    output en, up, clr, load, load_val,
    input  value, carry, seg, an
  );

  modport slave (
    input  clk,
    input  en, up, clr, load, load_val,
    output value, carry, seg, an
  );

endinterface

// File: rtl/seg_decoder.sv
// BCD digit to active-low gfedcba segment pattern;
// values above 9 decode to blank.
module seg_decoder
  import seg_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_BLANK;
    unique case (1'b1)
      (i_bcd == 4'd0): o_seg_n = ~SEG_0;
      (i_bcd == 4'd1): o_seg_n = ~SEG_1;
      (i_bcd == 4'd2): o_seg_n = ~SEG_2;
      (i_bcd == 4'd3): o_seg_n = ~SEG_3;
      (i_bcd == 4'd4): o_seg_n = ~SEG_4;
      (i_bcd == 4'd5): o_seg_n = ~SEG_5;
      (i_bcd == 4'd6): o_seg_n = ~SEG_6;
      (i_bcd == 4'd7): o_seg_n = ~SEG_7;
      (i_bcd == 4'd8): o_seg_n = ~SEG_8;
      (i_bcd == 4'd9): o_seg_n = ~SEG_9;
      default:         o_seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_counter_mux.sv
// Up/down BCD counter with multiplexed 7-segment scan output.
// Define SEG_COUNTER_BLANK_EN to blank leading zero digits.
module seg_counter_mux
  import seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int COUNT_DIV = 25000000,
  parameter int SCAN_DIV  = 100000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] value_o,
  output logic                carry_o,
  output logic [6:0]          disp_seg_o,
  output logic [7:0]          disp_an_o
);

  localparam int NB = 4 * DIGITS;
  localparam int PW = $clog2(COUNT_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [NB-1:0] r_val;
  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_scan;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [6:0]    r_seg;
  logic [7:0]    r_an;

  logic [NB-1:0] w_step;
  logic [NB-1:0] w_load_s;
  logic          w_wrap;
  logic          w_tick;
  logic          w_slot;
  logic          w_blank;
  logic [6:0]    w_seg_n;
  bcd_t          w_dig [DIGITS];

  assign w_tick = en && (r_pre == PW'(COUNT_DIV - 1));
  assign w_slot = (r_scan == SW'(SCAN_DIV - 1));

  // Ripple carry/borrow across digits; carry out of the top is the wrap
  always_comb begin
    logic c;
    c      = 1'b1;
    w_step = r_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (up) begin
          if (r_val[4*i+:4] == 4'd9) begin
            w_step[4*i+:4] = 4'd0;
          end else begin
            w_step[4*i+:4] = r_val[4*i+:4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (r_val[4*i+:4] == 4'd0) begin
            w_step[4*i+:4] = 4'd9;
          end else begin
            w_step[4*i+:4] = r_val[4*i+:4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    w_wrap = c;
  end

  always_comb begin
    w_load_s = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i+:4] > 4'd9) w_load_s[4*i+:4] = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_val   <= '0;
      r_pre   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      if (clr) begin
        r_val <= '0;
        r_pre <= '0;
      end else begin
        if (en) r_pre <= w_tick ? '0 : r_pre + PW'(1);
        if (load) begin
          r_val <= w_load_s;
        end else if (w_tick) begin
          r_val   <= w_step;
          r_carry <= w_wrap;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scan <= '0;
      r_idx  <= '0;
    end else begin
      r_scan <= w_slot ? '0 : r_scan + SW'(1);
      if (w_slot) begin
        r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign w_dig[g] = r_val[4*g+:4];
  end

  seg_decoder u_dec (
    .i_bcd   (w_dig[r_idx]),
    .o_seg_n (w_seg_n)
  );

`ifdef SEG_COUNTER_BLANK_EN
  assign w_blank = (r_idx != '0) &&
                   ((r_val >> {r_idx, 2'b00}) == '0);
`else
  assign w_blank = 1'b0;
`endif

  // Segments and anodes share one register stage so they never disagree
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seg <= SEG_BLANK;
      r_an  <= 8'hFF;
    end else begin
      r_seg <= w_blank ? SEG_BLANK : w_seg_n;
      r_an  <= ~(8'd1 << r_idx);
    end
  end

  assign value_o    = r_val;
  assign carry_o    = r_carry;
  assign disp_seg_o = r_seg;
  assign disp_an_o  = r_an;

endmodule

// File: tb/tb_seg_counter_mux.sv
// Self-checking bench for seg_counter_mux: two configurations
// checked against an integer-arithmetic reference model.
module tb_seg_counter_mux;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  int   m_val  [2];
  int   m_pre  [2];
  int   m_prev [2];
  bit   m_car  [2];

  logic [6:0] SEGT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  seg_counter_mux_if #(.DIGITS(2)) a_if (.clk(clk));
  seg_counter_mux_if #(.DIGITS(4)) b_if (.clk(clk));

  seg_counter_mux #(
    .DIGITS(2), .COUNT_DIV(4), .SCAN_DIV(3)
  ) dut_a (
    .clk(clk), .rstn(rstn),
    .en(a_if.en), .up(a_if.up), .clr(a_if.clr),
    .load(a_if.load), .load_val(a_if.load_val),
    .value_o(a_if.value), .carry_o(a_if.carry),
    .disp_seg_o(a_if.seg), .disp_an_o(a_if.an)
  );

  seg_counter_mux #(
    .DIGITS(4), .COUNT_DIV(3), .SCAN_DIV(2)
  ) dut_b (
    .clk(clk), .rstn(rstn),
    .en(b_if.en), .up(b_if.up), .clr(b_if.clr),
    .load(b_if.load), .load_val(b_if.load_val),
    .value_o(b_if.value), .carry_o(b_if.carry),
    .disp_seg_o(b_if.seg), .disp_an_o(b_if.an)
  );

  function automatic int p10(int n);
    int r = 1;
    for (int i = 0; i < n; i++) r *= 10;
    return r;
  endfunction

  function automatic int nd(int k);
    return (k == 1) ? 4 : 2;
  endfunction

  function automatic int cd(int k);
    return (k == 1) ? 3 : 4;
  endfunction

  function automatic logic [31:0] bcd(int v);
    logic [31:0] r = '0;
    for (int i = 0; i < 8; i++) r[4*i+:4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic int san(logic [31:0] lv, int n);
    int s = 0;
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      d = lv[4*i+:4];
      if (d <= 4'd9) s += int'(d) * p10(i);
    end
    return s;
  endfunction

  task automatic mdl(int k, logic e, logic u, logic c,
                     logic l, logic [31:0] lv);
    bit tick;
    int m;
    m         = p10(nd(k));
    m_prev[k] = m_val[k];
    m_car[k]  = 1'b0;
    tick      = e && (m_pre[k] == cd(k) - 1);
    if (c) begin
      m_val[k] = 0;
      m_pre[k] = 0;
    end else begin
      if (e) m_pre[k] = (m_pre[k] + 1) % cd(k);
      if (l) begin
        m_val[k] = san(lv, nd(k));
      end else if (tick) begin
        if (u) begin
          m_car[k] = (m_val[k] == m - 1);
          m_val[k] = (m_val[k] + 1) % m;
        end else begin
          m_car[k] = (m_val[k] == 0);
          m_val[k] = (m_val[k] + m - 1) % m;
        end
      end
    end
  endtask

  task automatic mrst();
    for (int k = 0; k < 2; k++) begin
      m_val[k]  = 0;
      m_pre[k]  = 0;
      m_prev[k] = 0;
      m_car[k]  = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rstn) begin
      mrst();
    end else begin
      mdl(0, a_if.en, a_if.up, a_if.clr, a_if.load,
          32'(a_if.load_val));
      mdl(1, b_if.en, b_if.up, b_if.clr, b_if.load,
          32'(b_if.load_val));
    end
    #1;
  endtask

  task automatic idle_inputs();
    a_if.en = 0; a_if.up = 0; a_if.clr = 0;
    a_if.load = 0; a_if.load_val = '0;
    b_if.en = 0; b_if.up = 0; b_if.clr = 0;
    b_if.load = 0; b_if.load_val = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rstn = 1'b0;
    mrst();
    #1;
    n_chk += 4;
    if (a_if.value !== 8'h00) begin
      n_fail++; $display("FAIL rst_a_val got %h exp 00", a_if.value);
    end
    if (a_if.carry !== 1'b0) begin
      n_fail++; $display("FAIL rst_a_carry got %b exp 0", a_if.carry);
    end
    if (a_if.seg !== 7'h7F) begin
      n_fail++; $display("FAIL rst_a_seg got %h exp 7f", a_if.seg);
    end
    if (a_if.an !== 8'hFF) begin
      n_fail++; $display("FAIL rst_a_an got %h exp ff", a_if.an);
    end
    n_chk += 2;
    if (b_if.value !== 16'h0000) begin
      n_fail++; $display("FAIL rst_b_val got %h exp 0000", b_if.value);
    end
    if (b_if.an !== 8'hFF || b_if.seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL rst_b_disp got %h/%h exp ff/7f", b_if.an, b_if.seg);
    end
    step();
    rstn = 1'b1;
    step();
    n_chk += 2;
    if (a_if.an !== 8'hFE || a_if.seg !== 7'h40) begin
      n_fail++;
      $display("FAIL first_a_disp got %h/%h exp fe/40", a_if.an, a_if.seg);
    end
    if (b_if.an !== 8'hFE || b_if.seg !== 7'h40) begin
      n_fail++;
      $display("FAIL first_b_disp got %h/%h exp fe/40", b_if.an, b_if.seg);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seen [$];
    logic [31:0] exp;
    logic [31:0] got;
    int ncar = 0;
    a_if.en = 1; a_if.up = 1;
    a_if.load = 1; a_if.load_val = 8'h98;
    step();
    a_if.load = 0;
    n_chk++;
    if (a_if.value !== 8'h98) begin
      n_fail++; $display("FAIL wrap_load got %h exp 98", a_if.value);
    end
    seen.push_back(a_if.value);
    repeat (16) begin
      step();
      exp = bcd(m_val[0]);
      n_chk += 2;
      if (a_if.value !== exp[7:0]) begin
        n_fail++;
        $display("FAIL wrap_val got %h exp %h", a_if.value, exp[7:0]);
      end
      if (a_if.carry !== m_car[0]) begin
        n_fail++;
        $display("FAIL wrap_carry got %b exp %b", a_if.carry, m_car[0]);
      end
      if (a_if.carry === 1'b1) begin
        ncar++;
        n_chk++;
        if (a_if.value !== 8'h00) begin
          n_fail++;
          $display("FAIL wrap_carry_at got %h exp 00", a_if.value);
        end
      end
      if (a_if.value !== seen[$]) seen.push_back(a_if.value);
    end
    got = (seen.size() >= 4) ? {seen[0], seen[1], seen[2], seen[3]} : '0;
    n_chk += 2;
    if (got !== 32'h98990001) begin
      n_fail++; $display("FAIL wrap_seq got %h exp 98990001", got);
    end
    if (ncar !== 1) begin
      n_fail++; $display("FAIL wrap_ncar got %0d exp 1", ncar);
    end
  endtask

  task automatic test_down();
    logic [7:0] seen [$];
    logic [31:0] exp;
    logic [15:0] got;
    int ncar = 0;
    a_if.en = 1; a_if.up = 0;
    a_if.load = 1; a_if.load_val = 8'h10;
    step();
    a_if.load = 0;
    seen.push_back(a_if.value);
    repeat (10) begin
      step();
      exp = bcd(m_val[0]);
      n_chk++;
      if (a_if.value !== exp[7:0]) begin
        n_fail++;
        $display("FAIL down_val got %h exp %h", a_if.value, exp[7:0]);
      end
      if (a_if.value !== seen[$]) seen.push_back(a_if.value);
    end
    n_chk++;
    if (seen.size() < 3 || seen[0] !== 8'h10 || seen[1] !== 8'h09 ||
        seen[2] !== 8'h08) begin
      n_fail++;
      $display("FAIL down_seq got %p exp 10,09,08", seen);
    end
    a_if.load = 1; a_if.load_val = 8'h00;
    step();
    a_if.load = 0;
    seen.delete();
    seen.push_back(a_if.value);
    repeat (6) begin
      step();
      n_chk++;
      if (a_if.carry !== m_car[0]) begin
        n_fail++;
        $display("FAIL down_carry got %b exp %b", a_if.carry, m_car[0]);
      end
      if (a_if.carry === 1'b1) ncar++;
      if (a_if.value !== seen[$]) seen.push_back(a_if.value);
    end
    got = (seen.size() >= 2) ? {seen[0], seen[1]} : '0;
    n_chk += 2;
    if (got !== 16'h0099) begin
      n_fail++; $display("FAIL down_wrap got %h exp 0099", got);
    end
    if (ncar !== 1) begin
      n_fail++; $display("FAIL down_ncar got %0d exp 1", ncar);
    end
  endtask

  task automatic test_priority();
    a_if.en = 1; a_if.up = 1;
    for (int i = 0; i < 8 && m_pre[0] != 2; i++) step();
    a_if.load = 1; a_if.load_val = 8'h99;
    step();
    a_if.load = 0;
    n_chk++;
    if (a_if.value !== 8'h99) begin
      n_fail++; $display("FAIL prio_setup got %h exp 99", a_if.value);
    end
    a_if.clr = 1; a_if.load = 1; a_if.load_val = 8'h55;
    step();
    a_if.clr = 0; a_if.load = 0;
    n_chk += 2;
    if (a_if.value !== 8'h00) begin
      n_fail++; $display("FAIL prio_val got %h exp 00", a_if.value);
    end
    if (a_if.carry !== 1'b0) begin
      n_fail++; $display("FAIL prio_carry got %b exp 0", a_if.carry);
    end
    repeat (3) step();
    n_chk++;
    if (a_if.value !== 8'h00) begin
      n_fail++; $display("FAIL prio_restart got %h exp 00", a_if.value);
    end
    step();
    n_chk++;
    if (a_if.value !== 8'h01) begin
      n_fail++; $display("FAIL prio_tick got %h exp 01", a_if.value);
    end
    for (int i = 0; i < 8 && m_pre[0] != 3; i++) step();
    a_if.load = 1; a_if.load_val = 8'h42;
    step();
    a_if.load = 0;
    n_chk++;
    if (a_if.value !== 8'h42 || a_if.carry !== 1'b0) begin
      n_fail++;
      $display("FAIL load_tick got %h/%b exp 42/0", a_if.value, a_if.carry);
    end
  endtask

  task automatic test_sanitize();
    a_if.en = 0; b_if.en = 0;
    a_if.load = 1; a_if.load_val = 8'h3A;
    b_if.load = 1; b_if.load_val = 16'hF1C5;
    step();
    a_if.load = 0; b_if.load = 0;
    n_chk += 2;
    if (a_if.value !== 8'h30) begin
      n_fail++; $display("FAIL san_a got %h exp 30", a_if.value);
    end
    if (b_if.value !== 16'h0105) begin
      n_fail++; $display("FAIL san_b got %h exp 0105", b_if.value);
    end
  endtask

  task automatic test_scan();
    logic [7:0] pa;
    logic [7:0] ea;
    logic [6:0] es;
    bit ok = 0;
    int i;
    b_if.en = 0;
    b_if.load = 1; b_if.load_val = 16'h1234;
    step();
    b_if.load = 0;
    pa = b_if.an;
    for (int t = 0; t < 20 && !ok; t++) begin
      step();
      if (pa !== 8'hFE && b_if.an === 8'hFE) ok = 1;
      pa = b_if.an;
    end
    n_chk++;
    if (!ok) begin
      n_fail++; $display("FAIL scan_sync got %h exp fe", b_if.an);
    end
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 2; c++) begin
        if (s != 0 || c != 0) step();
        i  = s % 4;
        ea = ~(8'd1 << i);
        es = ~SEGT[(1234 / p10(i)) % 10];
        n_chk += 2;
        if (b_if.an !== ea) begin
          n_fail++;
          $display("FAIL scan_an s%0d got %h exp %h", s, b_if.an, ea);
        end
        if (b_if.seg !== es) begin
          n_fail++;
          $display("FAIL scan_seg s%0d got %h exp %h", s, b_if.seg, es);
        end
      end
    end
    n_chk++;
    if (b_if.value !== 16'h1234) begin
      n_fail++; $display("FAIL freeze got %h exp 1234", b_if.value);
    end
  endtask

  task automatic test_random();
    logic [31:0] v, e;
    logic [7:0]  an;
    logic [6:0]  sg, es;
    logic        cr;
    int idx, dg;
    repeat (400) begin
      a_if.en   = ($urandom_range(3) != 0);
      a_if.up   = $urandom_range(1);
      a_if.clr  = ($urandom_range(31) == 0);
      a_if.load = ($urandom_range(15) == 0);
      a_if.load_val = 8'($urandom);
      b_if.en   = ($urandom_range(3) != 0);
      b_if.up   = $urandom_range(1);
      b_if.clr  = ($urandom_range(31) == 0);
      b_if.load = ($urandom_range(15) == 0);
      b_if.load_val = 16'($urandom);
      step();
      for (int k = 0; k < 2; k++) begin
        v  = k ? 32'(b_if.value) : 32'(a_if.value);
        cr = k ? b_if.carry : a_if.carry;
        an = k ? b_if.an : a_if.an;
        sg = k ? b_if.seg : a_if.seg;
        e  = bcd(m_val[k]) & ((32'd1 << (4 * nd(k))) - 1);
        n_chk += 3;
        if (v !== e) begin
          n_fail++; $display("FAIL rnd_val%0d got %h exp %h", k, v, e);
        end
        if (cr !== m_car[k]) begin
          n_fail++;
          $display("FAIL rnd_carry%0d got %b exp %b", k, cr, m_car[k]);
        end
        idx = -1;
        for (int j = 0; j < nd(k); j++) begin
          if (an === ~(8'd1 << j)) idx = j;
        end
        if (idx < 0) begin
          n_fail++; $display("FAIL rnd_an%0d got %h exp one-hot", k, an);
        end else begin
          dg = (m_prev[k] / p10(idx)) % 10;
          es = ~SEGT[dg];
`ifdef SEG_COUNTER_BLANK_EN
          if (idx > 0 && m_prev[k] < p10(idx)) es = 7'h7F;
`endif
          n_chk++;
          if (sg !== es) begin
            n_fail++;
            $display("FAIL rnd_seg%0d got %h exp %h", k, sg, es);
          end
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    a_if.en = 1; a_if.up = 1;
    b_if.en = 1; b_if.up = 1;
    b_if.load = 1; b_if.load_val = 16'h0457;
    step();
    b_if.load = 0;
    repeat (7) step();
    #3 rstn = 1'b0;
    mrst();
    #1;
    n_chk += 4;
    if (b_if.value !== 16'h0000 || b_if.carry !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_b_cnt got %h/%b exp 0000/0", b_if.value, b_if.carry);
    end
    if (b_if.seg !== 7'h7F || b_if.an !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_b_disp got %h/%h exp 7f/ff", b_if.seg, b_if.an);
    end
    if (a_if.value !== 8'h00 || a_if.carry !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_a_cnt got %h/%b exp 00/0", a_if.value, a_if.carry);
    end
    if (a_if.seg !== 7'h7F || a_if.an !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_a_disp got %h/%h exp 7f/ff", a_if.seg, a_if.an);
    end
    step();
    rstn = 1'b1;
    repeat (2) step();
    n_chk++;
    if (b_if.value !== 16'h0000) begin
      n_fail++; $display("FAIL mid_hold got %h exp 0000", b_if.value);
    end
    step();
    n_chk++;
    if (b_if.value !== 16'h0001) begin
      n_fail++; $display("FAIL mid_restart got %h exp 0001", b_if.value);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_down();
    test_priority();
    test_sanitize();
    test_scan();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
